// File: rtl/mmd_counter_if.sv
// Control and status bundle for the multi-modulus divider counter.
// The DSM/control side uses the master modport; the divider uses slave.
interface mmd_counter_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned OFS_W = 3
);
  logic             enable;
  logic [CNT_W-1:0] n_int;
  logic [OFS_W-1:0] dsm_ofs;
  logic             div_out;
  logic             div_strobe;
  logic [CNT_W-1:0] mod_cur;
  logic             sat;

  modport master (
    output enable, n_int, dsm_ofs,
    input  div_out, div_strobe, mod_cur, sat
  );

  modport slave (
    input  enable, n_int, dsm_ofs,
    output div_out, div_strobe, mod_cur, sat
  );
endinterface

// File: rtl/mmd_counter.sv
// Multi-modulus divider counter: divides by clamp(n_int + dsm_ofs) each period.
// Define MMD_DUTY50_EN for a ~50% duty div_out instead of a one-cycle pulse.
module mmd_counter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned OFS_W   = 3,
  parameter int unsigned MIN_DIV = 2
) (
  input logic          clk,
  input logic          rst,
  mmd_counter_if.slave bus
);

  localparam int unsigned ExtW = CNT_W + 2;
  localparam logic signed [ExtW-1:0] MinDiv = ExtW'(MIN_DIV);
  localparam logic signed [ExtW-1:0] MaxDiv = {2'b00, {CNT_W{1'b1}}};

  typedef enum logic {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mod_q, mod_d;
  logic             sat_q, sat_d;
  logic             strobe_q, strobe_d;
  logic             div_q, div_d;

  logic signed [ExtW-1:0] m_raw;
  logic [CNT_W-1:0]       m_clamp;
  logic                   m_sat;
  logic                   load;

  assign m_raw = $signed({2'b00, bus.n_int})
               + $signed({{(ExtW-OFS_W){bus.dsm_ofs[OFS_W-1]}}, bus.dsm_ofs});

  always_comb begin
    m_sat   = 1'b1;
    m_clamp = m_raw[CNT_W-1:0];
    if (m_raw < MinDiv) begin
      m_clamp = MinDiv[CNT_W-1:0];
    end else if (m_raw > MaxDiv) begin
      m_clamp = {CNT_W{1'b1}};
    end else begin
      m_sat = 1'b0;
    end
  end

  // Inputs are only sampled here: leaving IDLE, or at terminal count while still enabled.
  assign load = bus.enable && ((state_q == StIdle) || (cnt_q == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mod_d   = mod_q;
    sat_d   = sat_q;
    if (load) begin
      state_d = StRun;
      cnt_d   = m_clamp - CNT_W'(1);
      mod_d   = m_clamp;
      sat_d   = m_sat;
    end else if (state_q == StRun) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        state_d = StIdle;
        cnt_d   = '0;
        mod_d   = '0;
        sat_d   = 1'b0;
      end
    end
    // Outputs are precomputed from next state so they can leave straight from flops.
    strobe_d = (state_d == StRun) && (cnt_d == '0);
`ifdef MMD_DUTY50_EN
    div_d = (state_d == StRun) && (cnt_d >= (mod_d >> 1));
`else
    div_d = strobe_d;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mod_q    <= '0;
      sat_q    <= 1'b0;
      strobe_q <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mod_q    <= mod_d;
      sat_q    <= sat_d;
      strobe_q <= strobe_d;
      div_q    <= div_d;
    end
  end

  assign bus.div_out    = div_q;
  assign bus.div_strobe = strobe_q;
  assign bus.mod_cur    = mod_q;
  assign bus.sat        = sat_q;

endmodule

// File: tb/tb_mmd_counter.sv
// Self-checking bench for mmd_counter: table of modulus vectors with a period
// scoreboard, plus hand sequences for enable drop and asynchronous reset.
module tb_mmd_counter;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned OFS_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  mmd_counter_if #(.CNT_W(CNT_W), .OFS_W(OFS_W)) bus ();

  mmd_counter #(.CNT_W(CNT_W), .OFS_W(OFS_W), .MIN_DIV(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int n; int ofs; int m; int s;} vec_t;
  typedef struct {int m; int s;} exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int n, input int ofs);
    bus.n_int   = CNT_W'(n);
    bus.dsm_ofs = OFS_W'(ofs);
  endtask

  function automatic int outs_packed();
    return {21'd0, bus.div_out, bus.div_strobe, bus.mod_cur, bus.sat};
  endfunction

  // Counts cycles after the load edge up to and including the strobe cycle and
  // checks div_out against the expected waveform for modulus exp_m.
  task automatic run_period(input int exp_m, input bit scramble,
                            output int len, output int shape_err);
    bit exp_out;
    len       = 0;
    shape_err = 0;
    do begin
      @(negedge clk);
      len++;
`ifdef MMD_DUTY50_EN
      exp_out = (len <= (exp_m + 1) / 2);
`else
      exp_out = (len == exp_m);
`endif
      if (bus.div_out !== exp_out) shape_err++;
      if (scramble && len == 2 && !bus.div_strobe)
        drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)));
    end while (!bus.div_strobe && len < 600);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.div_strobe && n < 600);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    exp_t e;
    int   len, shape_err, n;

    vecs.push_back('{10,  0,  10, 0});
    vecs.push_back('{10,  0,  10, 0});
    vecs.push_back('{20,  1,  21, 0});
    vecs.push_back('{20, -2,  18, 0});
    vecs.push_back('{20,  3,  23, 0});
    vecs.push_back('{1,  -3,   2, 1});
    vecs.push_back('{1,  -3,   2, 1});
    vecs.push_back('{254, 3, 255, 1});
    vecs.push_back('{255, 0, 255, 0});
    vecs.push_back('{255, -4, 251, 0});
    vecs.push_back('{5,  -4,   2, 1});
    vecs.push_back('{0,  -1,   2, 1});
    vecs.push_back('{3,  -1,   2, 0});
    vecs.push_back('{7,   0,   7, 0});
    vecs.push_back('{6,   0,   6, 0});
    vecs.push_back('{7,  -4,   3, 0});

    bus.enable = 1'b0;
    drive(9, 1);
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_packed(), 0);
    bus.enable = 1'b1;
    @(negedge clk);
    check("reset_held_with_enable", outs_packed(), 0);
    bus.enable = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_enable", outs_packed(), 0);

    // Table run with enable held: each period's inputs are presented in the
    // previous strobe cycle and scrambled mid-period to prove they are ignored.
    drive(vecs[0].n, vecs[0].ofs);
    sb.push_back('{vecs[0].m, vecs[0].s});
    bus.enable = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      run_period(vecs[i].m, 1'b1, len, shape_err);
      e = sb.pop_front();
      check($sformatf("period[%0d]", i), len, e.m);
      check($sformatf("mod_cur[%0d]", i), int'(bus.mod_cur), e.m);
      check($sformatf("sat[%0d]", i), int'(bus.sat), e.s);
      check($sformatf("div_out_shape[%0d]", i), shape_err, 0);
      if (i + 1 < vecs.size()) begin
        drive(vecs[i+1].n, vecs[i+1].ofs);
        sb.push_back('{vecs[i+1].m, vecs[i+1].s});
      end else begin
        bus.enable = 1'b0;
      end
    end
    check("scoreboard_empty", sb.size(), 0);
    @(negedge clk);
    check("idle_after_table", outs_packed(), 0);

    // Enable drop with cnt=5: one more strobe five cycles later, then IDLE.
    drive(8, 0);
    bus.enable = 1'b1;
    repeat (3) @(negedge clk);
    check("drop_mod_cur", int'(bus.mod_cur), 8);
    bus.enable = 1'b0;
    wait_strobe(n);
    check("drop_last_strobe", n, 5);
    @(negedge clk);
    check("drop_idle", outs_packed(), 0);
    repeat (4) @(negedge clk);
    check("drop_stays_idle", outs_packed(), 0);
    bus.enable = 1'b1;
    wait_strobe(n);
    check("reenable_latency", n, 8);
    check("reenable_mod_cur", int'(bus.mod_cur), 8);

    // Asynchronous reset between edges with cnt=3.
    drive(6, 0);
    repeat (3) @(negedge clk);
    check("pre_reset_mod_cur", int'(bus.mod_cur), 6);
    #2 rst = 1'b0;
    #1 check("async_reset_outputs", outs_packed(), 0);
    @(negedge clk);
    check("reset_hold_outputs", outs_packed(), 0);
    drive(11, -1);
    rst = 1'b1;
    wait_strobe(n);
    check("post_reset_latency", n, 10);
    check("post_reset_mod_cur", int'(bus.mod_cur), 10);
    bus.enable = 1'b0;
    @(negedge clk);
    check("final_idle", outs_packed(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmd_counter.md
# mmd_counter

Programmable multi-modulus divider counter for the fractional-N feedback path. It sits directly downstream of the divide-by-4 prescaler and is clocked by the prescaler output. Each output period it divides by an integer modulus plus a signed per-period offset from the delta-sigma modulator. Its end-of-period strobe returns to the DSM as the update enable, and its output goes to the PFD.

## Interface
- `CNT_W`, default 8: counter and modulus width.
- `OFS_W`, default 3: width of the signed DSM offset, two's complement.
- `MIN_DIV`, default 2: smallest legal modulus. Must be at least 2.
- `clk`, input, 1: clock, driven by the prescaler output. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low. Assertion clears all state immediately; release is sampled on the next `clk` rising edge.
- `enable`, input, 1: run request.
- `n_int`, input, CNT_W: integer part of the modulus.
- `dsm_ofs`, input, OFS_W: signed offset from the DSM.
- `div_out`, output, 1: divided clock to the PFD, registered.
- `div_strobe`, output, 1: one-cycle pulse in the last cycle of each period, registered.
- `mod_cur`, output, CNT_W: modulus of the period in progress.
- `sat`, output, 1: high when the modulus of the current period was clamped.

## Operation
- Modulus calculation:
  - M_raw = `n_int` (zero-extended) + `dsm_ofs` (sign-extended), computed in CNT_W+2 bits.
  - M = clamp(M_raw, MIN_DIV, 2^CNT_W−1).
  - `sat` = (M ≠ M_raw).
- Sampling:
  - `n_int` and `dsm_ofs` are sampled only at a load edge: the IDLE→RUN edge, or the RUN terminal-count edge with `enable`=1.
  - Input changes at any other time have no effect on the period in progress.
- IDLE state:
  - Entered on reset. `cnt`=0 and all outputs are 0.
  - At an edge with `enable`=1: load `cnt`←M−1, `mod_cur`←M, update `sat`, go to RUN.
- RUN state:
  - `cnt` decrements by 1 on each edge.
  - At the edge where `cnt`=0 and `enable`=1: reload as above. No dead cycle; the next period starts immediately.
  - At the edge where `cnt`=0 and `enable`=0: go to IDLE. `cnt`, `mod_cur`, `sat` and `div_out` are cleared.
  - If `enable` drops mid-period, the current period completes, including its strobe, before returning to IDLE.
- Strobe:
  - `div_strobe`=1 exactly while in RUN with `cnt`=0.
  - It is driven from a flop: it is set on the edge that decrements `cnt` from 1 to 0.
- Reset mid-operation: asserting `rst` at any time forces IDLE with all outputs 0 asynchronously. No partial period resumes after release.

## Timing
- Enable latency: `enable` is sampled at edge E0. The first `div_strobe` is high in the cycle after edge E0+(M−1).
- Period: consecutive strobes are exactly M `clk` cycles apart, with M taken from the load edge that began each period.
- Offset pipeline:
  - The offset presented at a strobe cycle sets the length of the next period.
  - The DSM must update `dsm_ofs` on the edge that ends the strobe cycle, or earlier.
- Output timing: `mod_cur` and `sat` change only at load edges and hold their values for the whole period.
- Glitch freedom: all outputs come straight from flops. No combinational path exists from the inputs to any output.

## Configuration
- Macro: `MMD_DUTY50_EN`.
- Not defined: `div_out` equals `div_strobe`, giving a one-cycle-wide pulse per period.
- Defined:
  - `div_out`=1 in RUN while `cnt` ≥ (`mod_cur`>>1). It is high for ceil(M/2) cycles and low for floor(M/2) cycles per period.
  - `div_out` is a flop output, so the next-state compare is precomputed from the next `cnt`.
  - `div_strobe` is unchanged.

## Test plan
- Fixed division: `n_int`=10, `dsm_ofs`=0, `enable`=1 held → `div_strobe` every 10 cycles; `mod_cur`=10; `sat`=0; first strobe 9 edges after enable is sampled.
- Offset sequence: `n_int`=20; `dsm_ofs`=+1, −2, +3 presented in successive strobe cycles → period lengths 21, 18, 23. An offset change mid-period does not alter the current period.
- Saturation:
  - `n_int`=1, `dsm_ofs`=−3 → M=2, `sat`=1, strobe every 2 cycles.
  - `n_int`=254, `dsm_ofs`=+3 (CNT_W=8) → M=255, `sat`=1.
- Enable drop: `n_int`=8; `enable`→0 when `cnt`=5 → exactly one more strobe, 5 cycles later, then IDLE with all outputs 0. Re-enable restarts with the full latency.
- Async reset: `rst`→0 between edges with `cnt`=3 → all outputs 0 immediately. After release with `enable`=1, the first strobe arrives M−1 edges after the first sampled edge.
- Duty mode, with `MMD_DUTY50_EN` defined and `n_int`=7 → `div_out` high 4 cycles then low 3 per period. Separately, `n_int`=6 → high 3, low 3.
